// File: rtl/cenn_threshold_postproc_pkg.sv
// Shared types and helpers for the CeNN threshold post-processor.
// Build option CENN_AUTO_REPEAT_EN enables button auto-repeat in cenn_button_debounce.
package cenn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } btn_state_t;

  // Returned 32 bits wide so callers can compare without truncating; the value
  // always fits WIDTH_FIXED given the elaboration check in the top.
  function automatic logic signed [31:0] thr_value(input logic signed [31:0] idx,
                                                   input int step);
    return idx * step;
  endfunction

endpackage

// File: rtl/cenn_threshold_postproc_if.sv
// Pixel stream bus between the PE stage (master) and the post-processor (slave).
interface cenn_threshold_postproc_if #(
  parameter int NUM_TAPS    = 2,
  parameter int WIDTH_FIXED = 15,
  parameter int WIDTH_RGB   = 8
);
  logic                            in_valid;
  logic [NUM_TAPS*WIDTH_FIXED-1:0] out_cenn;
  logic                            out_valid;
  logic [NUM_TAPS*WIDTH_RGB-1:0]   black_white;

  modport master (output in_valid, out_cenn, input out_valid, black_white);
  modport slave  (input in_valid, out_cenn, output out_valid, black_white);
endinterface

// File: rtl/cenn_threshold_postproc_debounce.sv
// Button synchroniser + debounce FSM producing a 1-cycle step per accepted press.
// With CENN_AUTO_REPEAT_EN, a held button also steps every REPEAT_CYCLES.
module cenn_button_debounce
  import cenn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic step
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]   sync_q;
  logic         btn_s;
  btn_state_t   state;
  logic [CW-1:0] cnt;
  logic         press_step;

  assign btn_s = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], button};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      press_step <= 1'b0;
    end else begin
      press_step <= 1'b0;
      case (state)
        IDLE: if (btn_s) begin
          state <= DEB_PRESS;
          cnt   <= '0;
        end
        DEB_PRESS: begin
          if (!btn_s) state <= IDLE;
          else if (cnt == CNT_LAST) begin
            state      <= HELD;
            press_step <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        HELD: if (!btn_s) begin
          state <= DEB_REL;
          cnt   <= '0;
        end
        DEB_REL: begin
          if (btn_s) state <= HELD;
          else if (cnt == CNT_LAST) state <= IDLE;
          else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CENN_AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_step;

  // Gate on btn_s so the release edge itself never fires a repeat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt  <= '0;
      rep_step <= 1'b0;
    end else begin
      rep_step <= 1'b0;
      if (state == HELD && btn_s) begin
        if (rep_cnt == REP_LAST) begin
          rep_cnt  <= '0;
          rep_step <= 1'b1;
        end else rep_cnt <= rep_cnt + 1'b1;
      end else rep_cnt <= '0;
    end
  end

  assign step = press_step | rep_step;
`else
  assign step = press_step;
`endif

endmodule

// File: rtl/cenn_threshold_postproc.sv
// Binarises NUM_TAPS signed PE outputs against one button-adjustable threshold.
// Optional auto-repeat on the buttons via CENN_AUTO_REPEAT_EN.
module cenn_threshold_postproc
  import cenn_pkg::*;
#(
  parameter int WIDTH_FIXED     = 15,
  parameter int BIT_FRACTIONAL  = 9,
  parameter int WIDTH_RGB       = 8,
  parameter int NUM_TAPS        = 2,
  parameter int LED_WIDTH       = 5,
  parameter int THR_STEP        = 64,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          press_UP,
  input  logic                          press_DOWN,
  cenn_threshold_postproc_if.slave      pix,
  output logic [LED_WIDTH-1:0]          led
);
  localparam int STAGES = 2;
  localparam logic signed [LED_WIDTH-1:0] IDX_MAX = {1'b0, {(LED_WIDTH-1){1'b1}}};
  localparam logic signed [LED_WIDTH-1:0] IDX_MIN = {1'b1, {(LED_WIDTH-1){1'b0}}};

  if (THR_STEP * (2 ** (LED_WIDTH-1)) > 2 ** (WIDTH_FIXED-1)) begin : g_bad_param
    $error("cenn_threshold_postproc: THR_STEP range exceeds WIDTH_FIXED");
  end

  logic up_step, dn_step;

  cenn_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_up (.clk(clk), .reset(reset), .button(press_UP),   .step(up_step));
  cenn_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_dn (.clk(clk), .reset(reset), .button(press_DOWN), .step(dn_step));

  logic signed [LED_WIDTH-1:0] thr_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) thr_idx <= '0;
    else if (up_step && !dn_step && thr_idx != IDX_MAX) thr_idx <= thr_idx + 1'b1;
    else if (dn_step && !up_step && thr_idx != IDX_MIN) thr_idx <= thr_idx - 1'b1;
  end

  assign led = thr_idx;

  logic signed [31:0] thr;
  assign thr = thr_value(32'(thr_idx), THR_STEP);

  logic [NUM_TAPS-1:0] ge_d, ge_q;

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    logic signed [WIDTH_FIXED-1:0] tap;
    assign tap     = pix.out_cenn[k*WIDTH_FIXED +: WIDTH_FIXED];
    assign ge_d[k] = 32'(tap) >= thr;
  end

  logic [STAGES:1]               vld_pipe;
  logic [NUM_TAPS*WIDTH_RGB-1:0] bw_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      ge_q     <= '0;
      bw_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], pix.in_valid};
      ge_q     <= ge_d;
      // Invalid slots leave the last pixel on the bus.
      if (vld_pipe[1])
        for (int k = 0; k < NUM_TAPS; k++)
          bw_q[k*WIDTH_RGB +: WIDTH_RGB] <= {WIDTH_RGB{ge_q[k]}};
    end
  end

  assign pix.out_valid   = vld_pipe[STAGES];
  assign pix.black_white = bw_q;

endmodule
